// File: rtl/cond_logic_if.sv
`default_nettype none
// ============================================================================
// Module      : cond_logic_if
// Description : Decoder-to-conditional-execution bundle. The optional counter
//               signals exist only when COND_PERF_CNT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
interface cond_logic_if #(
    parameter int CNT_W = 16
);
    logic             En;
    logic [3:0]       Cond;
    logic [3:0]       ALUFlags;
    logic [1:0]       FlagW;
    logic             PCS;
    logic             RegW;
    logic             MemW;
    logic             PCSrc;
    logic             RegWrite;
    logic             MemWrite;
    logic             CondEx;
    logic [3:0]       Flags;
`ifdef COND_PERF_CNT_EN
    logic             CntClr;
    logic [CNT_W-1:0] ExecCount;
    logic [CNT_W-1:0] SquashCount;

    modport master (
        output En, Cond, ALUFlags, FlagW, PCS, RegW, MemW, CntClr,
        input  PCSrc, RegWrite, MemWrite, CondEx, Flags, ExecCount, SquashCount
    );
    modport slave (
        input  En, Cond, ALUFlags, FlagW, PCS, RegW, MemW, CntClr,
        output PCSrc, RegWrite, MemWrite, CondEx, Flags, ExecCount, SquashCount
    );
`else
    modport master (
        output En, Cond, ALUFlags, FlagW, PCS, RegW, MemW,
        input  PCSrc, RegWrite, MemWrite, CondEx, Flags
    );
    modport slave (
        input  En, Cond, ALUFlags, FlagW, PCS, RegW, MemW,
        output PCSrc, RegWrite, MemWrite, CondEx, Flags
    );
`endif
endinterface
`default_nettype wire

// File: rtl/cond_logic.sv
`default_nettype none
// ============================================================================
// Module      : cond_logic
// Description : ARM conditional-execution stage: NZCV register, condition
//               check and strobe gating. Define COND_PERF_CNT_EN to add
//               saturating executed/squashed instruction counters.
// Revision    : 1.0 - initial release
// ============================================================================
module cond_logic (
    input  wire logic    clk,
    input  wire logic    reset,
    cond_logic_if.slave  bus
);
    logic [3:0] r_flags;
    logic       w_n;
    logic       w_z;
    logic       w_c;
    logic       w_v;
    logic       w_pass;
    logic       w_condex;

    assign {w_n, w_z, w_c, w_v} = r_flags;

    // Evaluated against the flags held from previous instructions only.
    always_comb begin
        w_pass = 1'b0;
        case (bus.Cond)
            4'b0000: w_pass = w_z;
            4'b0001: w_pass = ~w_z;
            4'b0010: w_pass = w_c;
            4'b0011: w_pass = ~w_c;
            4'b0100: w_pass = w_n;
            4'b0101: w_pass = ~w_n;
            4'b0110: w_pass = w_v;
            4'b0111: w_pass = ~w_v;
            4'b1000: w_pass = w_c & ~w_z;
            4'b1001: w_pass = ~w_c | w_z;
            4'b1010: w_pass = (w_n == w_v);
            4'b1011: w_pass = (w_n != w_v);
            4'b1100: w_pass = ~w_z & (w_n == w_v);
            4'b1101: w_pass = w_z | (w_n != w_v);
            4'b1110: w_pass = 1'b1;
            default: w_pass = 1'b0;
        endcase
    end

    assign w_condex     = w_pass & bus.En;
    assign bus.CondEx   = w_condex;
    assign bus.PCSrc    = bus.PCS  & w_condex;
    assign bus.RegWrite = bus.RegW & w_condex;
    assign bus.MemWrite = bus.MemW & w_condex;
    assign bus.Flags    = r_flags;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_flags <= 4'b0000;
        end else begin
            if (bus.FlagW[1] & w_condex) r_flags[3:2] <= bus.ALUFlags[3:2];
            if (bus.FlagW[0] & w_condex) r_flags[1:0] <= bus.ALUFlags[1:0];
        end
    end

`ifdef COND_PERF_CNT_EN
    // Clear beats a same-cycle increment; both counters stick at all-ones.
    always_ff @(posedge clk) begin
        if (reset || bus.CntClr) begin
            bus.ExecCount   <= '0;
            bus.SquashCount <= '0;
        end else if (bus.En) begin
            if (w_pass) begin
                if (!(&bus.ExecCount)) bus.ExecCount <= bus.ExecCount + 1'b1;
            end else begin
                if (!(&bus.SquashCount)) bus.SquashCount <= bus.SquashCount + 1'b1;
            end
        end
    end
`endif

endmodule
`default_nettype wire
